// File: rtl/keypad_pkg.sv
// Shared types, register map and helpers for the 4x4 keypad scan controller.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } kp_state_t;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int DATA_VALID_BIT   = 4;
  localparam int STAT_VALID_BIT   = 0;
  localparam int STAT_OVERRUN_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT  = 0;

  // Index of the lowest column pulled low; columns are active-low.
  function automatic logic [1:0] lowest_col(input logic [3:0] cols_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!cols_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] row);
    return ~(4'b0001 << row);
  endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Column synchronizer, row dwell timer and scan/debounce FSM producing a
// one-cycle key strobe with its 4-bit code.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   ST_SCAN     | stepping rows each dwell tick, waiting for any column low
//   ST_DEBOUNCE | row held, column pattern must stay equal for DEB_TICKS
//   ST_PRESSED  | key accepted, row held until all columns read high
//   ST_RELEASE  | all-high must persist DEB_TICKS before scanning resumes
module keypad_debounce_fsm
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 12000,
  parameter int DEB_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       key_stb,
  output logic [3:0] key_code
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DEB_TICKS + 2);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_TICKS);

  logic [3:0]    col_s1, col_s2;
  logic [CW-1:0] dwell_cnt;
  logic          tick;
  logic          all_high;

  kp_state_t     state, state_nxt;
  logic [1:0]    row_idx, row_nxt;
  logic [3:0]    cap, cap_nxt;
  logic [DW-1:0] deb, deb_nxt, deb_inc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
    end
  end

  assign tick     = (dwell_cnt == DWELL_LAST);
  assign all_high = (col_s2 == 4'hF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  dwell_cnt <= '0;
    else if (tick) dwell_cnt <= '0;
    else           dwell_cnt <= dwell_cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row_idx;
    cap_nxt   = cap;
    deb_nxt   = deb;
    key_stb   = 1'b0;
    deb_inc   = deb + DW'(1);
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (all_high) begin
            row_nxt = row_idx + 2'd1;
          end else begin
            cap_nxt   = col_s2;
            deb_nxt   = DW'(1);
            state_nxt = ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          // The captured pattern always has a low bit, so equality excludes all-high.
          if (col_s2 == cap) begin
            deb_nxt = deb_inc;
            if (deb_inc >= DEB_LAST) begin
              key_stb   = 1'b1;
              state_nxt = ST_PRESSED;
            end
          end else begin
            state_nxt = ST_SCAN;
          end
        end
        ST_PRESSED: begin
          if (all_high) begin
            deb_nxt   = DW'(1);
            state_nxt = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (all_high) begin
            deb_nxt = deb_inc;
            if (deb_inc >= DEB_LAST) begin
              row_nxt   = row_idx + 2'd1;
              state_nxt = ST_SCAN;
            end
          end else begin
            state_nxt = ST_PRESSED;
          end
        end
        default: state_nxt = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_SCAN;
      row_idx <= 2'd0;
      cap     <= 4'hF;
      deb     <= '0;
      row_n   <= 4'b1110;
    end else begin
      state   <= state_nxt;
      row_idx <= row_nxt;
      cap     <= cap_nxt;
      deb     <= deb_nxt;
      row_n   <= row_drive(row_nxt);
    end
  end

  assign key_code = {row_idx, lowest_col(cap)};

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Avalon-MM keypad controller: scan/debounce engine plus DATA/STATUS/CTRL
// registers and a level interrupt.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 12000,
  parameter int DEB_TICKS = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  output logic        irq
);

  logic        key_stb;
  logic [3:0]  key_code;
  logic [3:0]  code;
  logic        valid, overrun, irq_en;
  logic        wr_status, clr_valid, clr_ovr;
  logic [31:0] rd_mux;
  logic        unused_inputs;

  keypad_debounce_fsm #(
    .SCAN_DIV  (SCAN_DIV),
    .DEB_TICKS (DEB_TICKS)
  ) u_fsm (
    .clk      (clk),
    .reset_n  (reset_n),
    .col_n    (col_n),
    .row_n    (row_n),
    .key_stb  (key_stb),
    .key_code (key_code)
  );

  assign wr_status = write && (address == ADDR_STATUS);
  assign clr_valid = wr_status && writedata[STAT_VALID_BIT];
  assign clr_ovr   = wr_status && writedata[STAT_OVERRUN_BIT];

  // A latch always beats a same-cycle clear; overrun looks at valid before the cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code    <= 4'd0;
      valid   <= 1'b0;
      overrun <= 1'b0;
      irq_en  <= 1'b0;
    end else begin
      if (key_stb) begin
        code  <= key_code;
        valid <= 1'b1;
      end else if (clr_valid) begin
        valid <= 1'b0;
      end
      if (key_stb && valid) overrun <= 1'b1;
      else if (clr_ovr)     overrun <= 1'b0;
      if (write && (address == ADDR_CTRL)) irq_en <= writedata[CTRL_IRQ_EN_BIT];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: begin
        rd_mux[3:0]            = code;
        rd_mux[DATA_VALID_BIT] = valid;
      end
      ADDR_STATUS: begin
        rd_mux[STAT_VALID_BIT]   = valid;
        rd_mux[STAT_OVERRUN_BIT] = overrun;
      end
      ADDR_CTRL: rd_mux[CTRL_IRQ_EN_BIT] = irq_en;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = valid & irq_en;

  assign unused_inputs = &{1'b0, read, writedata[31:2]};

endmodule
